count_uart_tx: RTL and testbench

COUNT_UART_TX -- requirements
Module: count_uart_tx

---
 rtl/count_uart_pkg.sv | 16 +
 rtl/count_uart_fifo.sv | 61 ++++++
 rtl/count_uart_tx.sv | 146 ++++++++++++++
 tb/tb_count_uart_tx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/count_uart_pkg.sv
// Shared types and defaults for the counter UART transmitter.
// Holds the frame FSM states and the default timing and buffer sizes.
package count_uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DEFAULT_FIFO_DEPTH   = 4;
    localparam int FRAME_BITS           = 10;  // start + 8 data + stop

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

endpackage

// File: rtl/count_uart_fifo.sv
// Single-clock byte FIFO with registered full/empty/level flags.
// The read data is the current head entry, shown without waiting for a pop.
module count_uart_fifo
    import count_uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [4:0]       level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;
    logic [4:0]       level_next;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_comb begin
        level_next = level + {4'b0, do_wr} - {4'b0, do_rd};
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level_next;
            full  <= (level_next == 5'(DEPTH));
            empty <= (level_next == 5'd0);
        end
    end

    // NOTE: storage is not reset; the level/pointers already mark every entry invalid.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/count_uart_tx.sv
// 8N1 UART transmitter fed by a small FIFO of counter bytes.
// Frames run back-to-back while bytes are queued; tx comes straight from a flop.
module count_uart_tx
    import count_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx,
    output logic       busy,
    output logic       overflow,
    output logic [4:0] fifo_level
);

    localparam int DATA_BITS = FRAME_BITS - 2;

    uart_state_e state, state_n;
    logic [9:0]  baud, baud_n;
    logic [2:0]  bit_idx, bit_n;
    logic [7:0]  shreg, shreg_n;
    logic        tx_q, tx_n;
    logic        overflow_q;
    logic        bit_end;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_head;

    // Readiness comes from registered occupancy, so a same-edge pop never frees a slot.
    assign data_ready = !fifo_full;
    assign push       = data_valid && !fifo_full;

    count_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (data_in),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign bit_end = (baud == 10'(CLKS_PER_BIT - 1));

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state;
        baud_n  = baud;
        bit_n   = bit_idx;
        shreg_n = shreg;
        tx_n    = tx_q;
        pop     = 1'b0;

        unique case (state)
            IDLE: begin
                baud_n = '0;
                tx_n   = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_n = fifo_head;
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = DATA;
                    tx_n    = shreg[0];
                end else begin
                    baud_n = baud + 10'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_n = '0;
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n   = bit_idx + 3'd1;
                        shreg_n = {1'b0, shreg[7:1]};
                        tx_n    = shreg[1];
                    end
                end else begin
                    baud_n = baud + 10'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_n = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_n = fifo_head;
                        state_n = START;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end else begin
                    baud_n = baud + 10'd1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            baud       <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_n;
            shreg   <= shreg_n;
            tx_q    <= tx_n;
            if (data_valid && fifo_full) overflow_q <= 1'b1;
        end
    end

    assign tx       = tx_q;
    assign overflow = overflow_q;
    assign busy     = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_count_uart_tx.sv
// Scoreboard bench for count_uart_tx: a queue-level model predicts acceptance,
// occupancy and frame start edges; a monitor decodes tx frames and pops expectations.
module tb_count_uart_tx;

    localparam int CPB       = 4;
    localparam int DEPTH     = 4;
    localparam int FRAME_CYC = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       tx;
    logic       busy;
    logic       overflow;
    logic [4:0] fifo_level;

    count_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_k = 0;

    // Reference model: pending bytes waiting for the shifter, and when the current frame ends.
    logic [7:0] pend_q[$];
    logic [7:0] exp_byte_q[$];
    int         exp_start_q[$];
    int         frame_end = 0;
    int         last_start = -1;
    bit         m_ovf = 1'b0;
    bit         frame_abort = 1'b0;
    int         peak_level = 0;

    // Monitor state
    bit         in_frame = 1'b0;
    int         s_edge;
    int         off;
    int         idx;
    logic [9:0] bits;
    logic [7:0] e_b;
    int         e_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_k);
        end
    endtask

    function automatic void model_edge(input bit v, input logic [7:0] d);
        bit do_pop;
        bit accept;
        do_pop = (edge_k >= frame_end) && (pend_q.size() > 0);
        accept = v && (pend_q.size() < DEPTH);
        if (v && !accept) m_ovf = 1'b1;
        if (do_pop) begin
            void'(pend_q.pop_front());
            exp_start_q.push_back(edge_k);
            last_start = edge_k;
            frame_end  = edge_k + FRAME_CYC;
        end
        if (accept) begin
            pend_q.push_back(d);
            exp_byte_q.push_back(d);
        end
    endfunction

    // One clock cycle: drive at negedge, model at posedge, compare at the next negedge.
    task automatic step(input bit v, input logic [7:0] d);
        data_valid = v;
        data_in    = d;
        @(posedge clk);
        edge_k++;
        if (rst_n) model_edge(v, d);
        @(negedge clk);
        data_valid = 1'b0;
        if (rst_n) begin
            check("fifo_level", fifo_level, pend_q.size());
            check("data_ready", data_ready, pend_q.size() < DEPTH);
            check("overflow", overflow, m_ovf);
            check("busy", busy, (edge_k < frame_end) || (pend_q.size() > 0));
            if (int'(fifo_level) > peak_level) peak_level = int'(fifo_level);
        end
    endtask

    task automatic apply_reset(input int hold);
        #2 rst_n = 1'b0;
        pend_q.delete();
        exp_byte_q.delete();
        exp_start_q.delete();
        frame_end   = 0;
        m_ovf       = 1'b0;
        frame_abort = 1'b1;
        #1;
        check("rst_tx", tx, 1);
        check("rst_level", fifo_level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", data_ready, 1);
        repeat (hold) step(1'b0, 8'h00);
        rst_n = 1'b1;
    endtask

    // Frame monitor: bit i of a frame is sampled CPB*i+1 edges after its start edge.
    initial begin
        forever begin
            @(negedge clk);
            if (frame_abort) begin
                frame_abort = 1'b0;
                in_frame    = 1'b0;
            end else if (!in_frame) begin
                if (rst_n && tx == 1'b0) begin
                    in_frame = 1'b1;
                    s_edge   = edge_k;
                    bits     = '0;
                end
            end else begin
                off = edge_k - s_edge;
                if ((off % CPB) == 1) begin
                    idx       = off / CPB;
                    bits[idx] = tx;
                    if (idx == 9) begin
                        in_frame = 1'b0;
                        if (exp_byte_q.size() == 0 || exp_start_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_frame: got %b expected no frame", bits);
                        end else begin
                            e_b = exp_byte_q.pop_front();
                            e_s = exp_start_q.pop_front();
                            check("frame_bits", bits, {1'b1, e_b, 1'b0});
                            check("frame_start_edge", s_edge, e_s);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        @(negedge clk);
        apply_reset(3);

        // Push on the first edge after release; 0xA5 frame with start bit on the next edge.
        step(1'b1, 8'hA5);
        repeat (FRAME_CYC + 5) step(1'b0, 8'h00);
        check("busy_after_a5", busy, 0);

        // Three consecutive pushes -> three contiguous frames.
        peak_level = 0;
        step(1'b1, 8'h00);
        step(1'b1, 8'hFF);
        step(1'b1, 8'h3C);
        repeat (3 * FRAME_CYC + 5) step(1'b0, 8'h00);
        check("peak_level_3bytes", peak_level, 2);

        // Six back-to-back pushes: one goes to the shifter, four fill the FIFO, the sixth drops.
        for (int i = 0; i < 6; i++) step(1'b1, 8'h10 + 8'(i));
        check("overflow_set", overflow, 1);
        check("ready_low_full", data_ready, 0);

        // Keep pushing while full; the pop edge must still reject the push.
        guard = 0;
        while (pend_q.size() == DEPTH && guard < 100) begin
            step(1'b1, 8'($urandom));
            guard++;
        end
        check("level_after_full_pop", fifo_level, 3);
        check("overflow_sticky", overflow, 1);
        repeat (5 * FRAME_CYC) step(1'b0, 8'h00);

        // Reset in the middle of data bit 4 of 0x81 with another byte buffered.
        step(1'b1, 8'h81);
        step(1'b1, 8'h55);
        guard = 0;
        while (edge_k < last_start + 5 * CPB + 1 && guard < 200) begin
            step(1'b0, 8'h00);
            guard++;
        end
        check("tx_bit4_of_81", tx, 0);
        apply_reset(2);
        step(1'b1, 8'h42);
        repeat (FRAME_CYC + 10) step(1'b0, 8'h00);

        // Randomized traffic, including overflow attempts.
        repeat (600) step($urandom_range(0, 3) == 0, 8'($urandom));
        repeat (6 * FRAME_CYC) step(1'b0, 8'h00);

        check("sb_bytes_drained", exp_byte_q.size(), 0);
        check("sb_starts_drained", exp_start_q.size(), 0);
        check("monitor_idle", in_frame, 0);
        check("final_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
